kj_ring_buffer: RTL and testbench
=================================

Name: kj_ring_buffer

Overview:
- Parametrised K-in / J-out width-converting ring buffer.
- Successor to the fixed-address K-write/J-read buffer. Adds internal read/write pointers with wrap-around, an occupancy counter, write-side ready, read-side avail/valid handshakes, and legal simultaneous read and write.
- Sits between a K-lane producer and a J-lane consumer in the datapath.

Parameters:
- WIDTH, 8, bits per element.
- K, 4, elements written per accepted write; 1 ≤ K ≤ DEPTH.
- J, 2, elements read per accepted read; 1 ≤ J ≤ DEPTH.
- DEPTH, 16, element capacity; must be a power of two.
- AF_LEVEL, 12, almost_full threshold in elements.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on the clk rising edge).
- w_en  in  1  write request.
- par_in  in  WIDTH*K  write data; lane i = par_in[i*WIDTH +: WIDTH]; lane 0 is oldest.
- r_en  in  1  read request.
- par_out  out  WIDTH*J  read data, registered; lane 0 is oldest.
- valid  out  1  par_out updated this cycle (one-cycle pulse per accepted read).
- ready  out  1  free space ≥ K.
- avail  out  1  count ≥ J.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy in elements.
- overflow  out  1  sticky error flag (see Optional Feature).
- underflow  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - par_out=0, valid=0, overflow=0, underflow=0.
  - Outputs then settle to ready=1, avail=0 (when J>0), empty=1, full=0, almost_full=(AF_LEVEL==0).
  - Storage contents are not cleared.
- Reset mid-operation: any in-flight read is discarded; valid=0 on the following cycle; no write is committed.
- ready, avail, full, empty and almost_full are combinational from the count register only, never from w_en or r_en.
- Write accept: wr_acc = w_en & ready.
  - mem[(wr_ptr+i) mod DEPTH] ← lane i, for i = 0..K-1.
  - wr_ptr ← (wr_ptr+K) mod DEPTH.
- Read accept: rd_acc = r_en & avail.
  - par_out lane i ← mem[(rd_ptr+i) mod DEPTH], for i = 0..J-1.
  - rd_ptr ← (rd_ptr+J) mod DEPTH.
  - valid=1 on the next cycle; latency is 1 clk.
- Without rd_acc: valid=0 and par_out holds its last value.
- count_next = count + K*wr_acc − J*rd_acc. Compute at count width + 1 bit; the result never leaves 0..DEPTH.
- Simultaneous read and write:
  - Both are accepted independently, judged on the pre-edge count.
  - No same-cycle bypass: data written in cycle n is readable from cycle n+1 at the earliest.
  - Read and write regions never overlap, so there is no read/write collision.
- Wrap-around: pointer arithmetic is modulo DEPTH per lane, so a single K- or J-group may straddle index DEPTH-1 → 0.
- Non-divisible K/J: partial occupancy is legal, e.g. count=1 with J=2 gives avail=0. Elements stay until enough arrive.
- Rejected requests (w_en with !ready, r_en with !avail) change no state and do not touch par_out.

Optional Feature:
- Macro: KJ_RING_BUFFER_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle with w_en & !ready.
  - underflow sets on any cycle with r_en & !avail.
  - Both flags are sticky until reset.
- Undefined: overflow and underflow are tied to 0; no flag registers are synthesised.

Test Plan:
- Reset, then a write with par_in=32'h04030201 → next cycle count=4, empty=0, avail=1. Then a read → one cycle later par_out=16'h0201 with valid=1; count=2.
- Four writes back-to-back from empty → count=16, full=1, ready=0, almost_full=1. A fifth w_en is ignored, count stays 16, and overflow=1 with the macro on.
- From full, read once → count=14, still ready=0. Read again → count=12, ready=1. A write then wraps (wr_ptr 0→4). Subsequent reads return elements in exact write order across the wrap.
- At count=8, assert w_en and r_en in the same cycle → count=10, valid=1 next cycle with the oldest two elements.
- r_en at count=1 → no valid pulse, count stays 1, par_out unchanged; underflow=1 with the macro on and 0 without.
- Drive rst=0 for one cycle during a read at count=6 → next cycle count=0, valid=0, empty=1, ready=1; sticky flags cleared.

Source files
------------

// File: rtl/kj_ring_buffer.sv
// kj_ring_buffer: K-in / J-out width-converting ring buffer.
// K elements are written per accepted write and J elements are read per
// accepted read. Internal pointers wrap modulo DEPTH, so DEPTH must be a
// power of two.
// Optional feature: define KJ_RING_BUFFER_ERR_FLAGS_EN to build the sticky
// overflow/underflow flags. Without the macro both outputs are tied low.
module kj_ring_buffer #(
  parameter int WIDTH    = 8,
  parameter int K        = 4,
  parameter int J        = 2,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [WIDTH*K-1:0]   par_in,
  input  logic                 r_en,
  output logic [WIDTH*J-1:0]   par_out,
  output logic                 valid,
  output logic                 ready,
  output logic                 avail,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH*J-1:0] par_out_r;
  logic               valid_r;

  logic [CW:0]        free_s;
  logic [CW:0]        cnt_ext_s;
  logic               ready_s;
  logic               avail_s;
  logic               wr_acc_s;
  logic               rd_acc_s;

  // Index of lane 'off' relative to a pointer, wrapped modulo DEPTH.
  function automatic logic [PW-1:0] wrap_idx_f(input logic [PW-1:0] base, input int off);
    wrap_idx_f = (base + PW'(off)) & PW'(DEPTH - 1);
  endfunction

  // Space/occupancy flags, accept strobes and next occupancy, all derived
  // from the registered count only (never from the request inputs).
  always_comb begin
    free_s    = (CW+1)'(DEPTH) - {1'b0, count_r};
    ready_s   = (free_s >= (CW+1)'(K));
    avail_s   = ({1'b0, count_r} >= (CW+1)'(J));
    wr_acc_s  = w_en & ready_s;
    rd_acc_s  = r_en & avail_s;
    cnt_ext_s = {1'b0, count_r}
              + (wr_acc_s ? (CW+1)'(K) : (CW+1)'(0))
              - (rd_acc_s ? (CW+1)'(J) : (CW+1)'(0));
  end

  // Storage write: K lanes land at consecutive wrapped addresses; never
  // cleared by reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_acc_s) begin
      for (int i = 0; i < K; i++) begin
        mem_r[wrap_idx_f(wr_ptr_r, i)] <= par_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      par_out_r <= {(WIDTH*J){1'b0}};
      valid_r   <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wrap_idx_f(wr_ptr_r, K);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= wrap_idx_f(rd_ptr_r, J);
        for (int j = 0; j < J; j++) begin
          par_out_r[j*WIDTH +: WIDTH] <= mem_r[wrap_idx_f(rd_ptr_r, j)];
        end
      end else begin
        rd_ptr_r  <= rd_ptr_r;
        par_out_r <= par_out_r;
      end
      valid_r <= rd_acc_s;
      // A negative intermediate cannot occur with gated accepts; if it ever
      // did, holding the count is safer than wrapping it.
      count_r <= cnt_ext_s[CW] ? count_r : cnt_ext_s[CW-1:0];
    end
  end

`ifdef KJ_RING_BUFFER_ERR_FLAGS_EN
  logic ovf_r;
  logic unf_r;

  // Sticky error flags: set on any rejected request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (w_en && !ready_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      if (r_en && !avail_s) begin
        unf_r <= 1'b1;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign overflow  = ovf_r;
  assign underflow = unf_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign par_out     = par_out_r;
  assign valid       = valid_r;
  assign count       = count_r;
  assign ready       = ready_s;
  assign avail       = avail_s;
  assign full        = (count_r == CW'(DEPTH));
  assign empty       = (count_r == CW'(0));
  assign almost_full = (32'(count_r) >= $unsigned(AF_LEVEL));

endmodule

// File: tb/tb_kj_ring_buffer.sv
// Self-checking bench for kj_ring_buffer: directed vector table, a short
// hand sequence for the threshold flags, and randomized traffic compared
// against a queue-based reference model.
module tb_kj_ring_buffer;

  localparam int WIDTH    = 8;
  localparam int K        = 4;
  localparam int J        = 2;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;
  localparam int CW       = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 w_en;
  logic [WIDTH*K-1:0]   par_in;
  logic                 r_en;
  logic [WIDTH*J-1:0]   par_out;
  logic                 valid;
  logic                 ready;
  logic                 avail;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [WIDTH-1:0]   q[$];
  logic [WIDTH*J-1:0] m_par;
  bit                 m_valid;
  bit                 m_ovf;
  bit                 m_unf;

  typedef struct {
    bit          rst_v;
    bit          w;
    bit          r;
    logic [31:0] data;
    int          exp_count;
    bit          exp_valid;
    logic [15:0] exp_par;
  } vec_t;

  vec_t vecs[28];

  always #5 clk = ~clk;

  kj_ring_buffer #(
    .WIDTH(WIDTH), .K(K), .J(J), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .par_in(par_in), .r_en(r_en),
    .par_out(par_out), .valid(valid), .ready(ready), .avail(avail),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by the spec rules, then compare.
  task automatic cycle(input bit rst_v, input bit w, input bit r, input logic [31:0] d);
    int sz;
    bit wacc;
    bit racc;
    rst    = rst_v;
    w_en   = w;
    r_en   = r;
    par_in = d;
    if (!rst_v) begin
      q.delete();
      m_par   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      sz   = q.size();
      wacc = w && ((DEPTH - sz) >= K);
      racc = r && (sz >= J);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_unf = 1'b1;
      m_valid = racc;
      if (racc) begin
        for (int i = 0; i < J; i++) m_par[i*WIDTH +: WIDTH] = q.pop_front();
      end
      if (wacc) begin
        for (int i = 0; i < K; i++) q.push_back(d[i*WIDTH +: WIDTH]);
      end
    end
    @(posedge clk);
    #1;
    chk("count",       32'(count),       32'(q.size()));
    chk("valid",       32'(valid),       32'(m_valid));
    chk("par_out",     32'(par_out),     32'(m_par));
    chk("ready",       32'(ready),       32'((DEPTH - q.size()) >= K));
    chk("avail",       32'(avail),       32'(q.size() >= J));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
`ifdef KJ_RING_BUFFER_ERR_FLAGS_EN
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("underflow",   32'(underflow),   32'(m_unf));
`else
    chk("overflow",    32'(overflow),    32'(0));
    chk("underflow",   32'(underflow),   32'(0));
`endif
  endtask

  initial begin
    rst    = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    par_in = '0;

    //            rst   w     r     data          cnt valid par
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 0,  1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h04030201, 4,  1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h00000000, 2,  1'b1, 16'h0201};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h00000000, 0,  1'b1, 16'h0403};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h13121110, 4,  1'b0, 16'h0403};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h17161514, 8,  1'b0, 16'h0403};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h1b1a1918, 12, 1'b0, 16'h0403};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h1f1e1d1c, 16, 1'b0, 16'h0403};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'haaaaaaaa, 16, 1'b0, 16'h0403};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h00000000, 14, 1'b1, 16'h1110};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 12, 1'b1, 16'h1312};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h23222120, 16, 1'b0, 16'h1312};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 14, 1'b1, 16'h1514};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 12, 1'b1, 16'h1716};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 10, 1'b1, 16'h1918};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 8,  1'b1, 16'h1b1a};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h27262524, 10, 1'b1, 16'h1d1c};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 8,  1'b1, 16'h1f1e};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 6,  1'b1, 16'h2120};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 4,  1'b1, 16'h2322};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 2,  1'b1, 16'h2524};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 0,  1'b1, 16'h2726};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 0,  1'b0, 16'h2726};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 32'h33323130, 4,  1'b0, 16'h2726};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 32'h37363534, 8,  1'b0, 16'h2726};
    vecs[25] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 6,  1'b1, 16'h3130};
    vecs[26] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 0,  1'b0, 16'h0000};
    vecs[27] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 0,  1'b0, 16'h0000};

    for (int i = 0; i < 28; i++) begin
      cycle(vecs[i].rst_v, vecs[i].w, vecs[i].r, vecs[i].data);
      chk($sformatf("vec%0d_count", i), 32'(count),   32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 32'(valid),   32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_par", i),   32'(par_out), 32'(vecs[i].exp_par));
    end

    // Threshold flags around almost_full and full with fixed expectations.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h44434241);
    cycle(1'b1, 1'b1, 1'b0, 32'h48474645);
    chk("af_below", 32'(almost_full), 32'(0));
    cycle(1'b1, 1'b1, 1'b0, 32'h4c4b4a49);
    chk("af_at_level",   32'(almost_full), 32'(1));
    chk("ready_at_12",   32'(ready),       32'(1));
    chk("full_at_12",    32'(full),        32'(0));
    cycle(1'b1, 1'b1, 1'b1, 32'h504f4e4d);
    chk("count_wr_rd_12", 32'(count),   32'(14));
    chk("par_wr_rd_12",   32'(par_out), 32'(16'h4241));
    chk("ready_at_14",    32'(ready),   32'(0));

    // Randomized traffic in phases biased toward filling then draining.
    for (int n = 0; n < 3000; n++) begin
      int wb;
      int rb;
      wb = (n % 600 < 300) ? 75 : 30;
      rb = (n % 600 < 300) ? 35 : 80;
      cycle(($urandom_range(0, 249) != 0),
            ($urandom_range(0, 99) < wb),
            ($urandom_range(0, 99) < rb),
            $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
